// File: rtl/axi4_bram_responder_if.sv
// AXI4 bus bundle shared by the frame buffer master ports and the BRAM responder.
// Carries all five channels; each side uses the subset it needs.
interface axi4_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_bram_responder.sv
// AXI4 slave backed by dual-port RAM with independent write and read burst engines.
// Define AXI4_BRAM_RESPONDER_STALL_EN to gate readies/beat issue with an LFSR for stress.
module axi4_bram_responder #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
  parameter int unsigned             MEM_WORDS  = 8192,
  parameter int unsigned             DATA_WIDTH = 64,
  parameter int unsigned             ID_WIDTH   = 1
) (
  input logic   clk_i,
  input logic   rst_i,
  axi4_if.slave mem_wr,
  axi4_if.slave mem_rd
);

  localparam int unsigned Lanes    = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(Lanes);
  localparam int unsigned WordBits = $clog2(MEM_WORDS);
  localparam int unsigned PtrW     = WordBits + 1;
  localparam logic [ADDR_WIDTH-1:0] MemWordsA = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [PtrW-1:0]       PtrOor    = {1'b1, {WordBits{1'b0}}};

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic [0:0] {RIdle, RData} rstate_e;

  // Top pointer bit means "past the end of RAM"; it is sticky so long bursts never wrap.
  function automatic logic [PtrW-1:0] to_ptr(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] idx;
    idx = (addr - BASE_ADDR) >> LaneBits;
    return (idx < MemWordsA) ? idx[PtrW-1:0] : PtrOor;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr, input logic fixed);
    return (fixed || ptr[WordBits]) ? ptr : ptr + PtrW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic                  r_live;
  logic                  w_go_aw, w_go_w, w_go_r;

`ifdef AXI4_BRAM_RESPONDER_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Each gate is low when its two-bit slice is zero, i.e. on about a quarter of cycles.
  assign w_go_aw = |r_lfsr[1:0];
  assign w_go_w  = |r_lfsr[5:4];
  assign w_go_r  = |r_lfsr[9:8];
`else
  assign w_go_aw = 1'b1;
  assign w_go_w  = 1'b1;
  assign w_go_r  = 1'b1;
`endif

  // Keeps address readies low for the first cycle after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  // ---------------------------------------------------------------- write engine
  wstate_e               r_wstate, w_wstate_d;
  logic [PtrW-1:0]       r_w_ptr;
  logic                  r_w_fixed;
  logic [7:0]            r_w_len;
  logic [7:0]            r_w_cnt;
  logic [ID_WIDTH-1:0]   r_w_id;
  logic                  r_w_err;
  logic                  w_awready, w_wready, w_bvalid;
  logic                  w_aw_hs, w_w_hs, w_w_final, w_w_oor, w_mem_we;
  logic [WordBits-1:0]   w_w_idx;

  assign w_w_final = (r_w_cnt == r_w_len);
  assign w_w_oor   = r_w_ptr[WordBits];
  assign w_w_idx   = r_w_ptr[WordBits-1:0];
  assign w_aw_hs   = mem_wr.awvalid & w_awready;
  assign w_w_hs    = mem_wr.wvalid & w_wready;
  assign w_mem_we  = w_w_hs & ~w_w_oor & ~rst_i;

  always_comb begin
    w_wstate_d = r_wstate;
    w_awready  = 1'b0;
    w_wready   = 1'b0;
    w_bvalid   = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        w_awready = r_live & w_go_aw;
        if (mem_wr.awvalid && w_awready) w_wstate_d = WData;
      end
      WData: begin
        w_wready = w_go_w;
        if (mem_wr.wvalid && w_wready && w_w_final) w_wstate_d = WResp;
      end
      WResp: begin
        w_bvalid = 1'b1;
        if (mem_wr.bready) w_wstate_d = WIdle;
      end
      default: w_wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate  <= WIdle;
      r_w_ptr   <= '0;
      r_w_fixed <= 1'b0;
      r_w_len   <= '0;
      r_w_cnt   <= '0;
      r_w_id    <= '0;
      r_w_err   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_d;
      if (w_aw_hs) begin
        r_w_ptr   <= to_ptr(mem_wr.awaddr);
        r_w_fixed <= (mem_wr.awburst == 2'b00);
        r_w_len   <= mem_wr.awlen;
        r_w_cnt   <= '0;
        r_w_id    <= mem_wr.awid;
        r_w_err   <= mem_wr.awburst[1];
      end else if (w_w_hs) begin
        r_w_ptr <= next_ptr(r_w_ptr, r_w_fixed);
        r_w_cnt <= r_w_cnt + 8'd1;
        if (w_w_oor || (mem_wr.wlast != w_w_final)) r_w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < Lanes; b++) begin
        if (mem_wr.wstrb[b]) r_mem[w_w_idx][b*8 +: 8] <= mem_wr.wdata[b*8 +: 8];
      end
    end
  end

  assign mem_wr.awready = w_awready;
  assign mem_wr.wready  = w_wready;
  assign mem_wr.bvalid  = w_bvalid;
  assign mem_wr.bid     = r_w_id;
  assign mem_wr.bresp   = (w_bvalid && r_w_err) ? 2'b10 : 2'b00;
  assign mem_wr.arready = 1'b0;
  assign mem_wr.rvalid  = 1'b0;
  assign mem_wr.rid     = '0;
  assign mem_wr.rdata   = '0;
  assign mem_wr.rresp   = 2'b00;
  assign mem_wr.rlast   = 1'b0;

  // ----------------------------------------------------------------- read engine
  rstate_e               r_rstate, w_rstate_d;
  logic [PtrW-1:0]       r_r_ptr;
  logic                  r_r_fixed;
  logic [7:0]            r_r_len;
  logic [8:0]            r_r_icnt;
  logic [ID_WIDTH-1:0]   r_r_id;
  logic                  r_r_err;
  // q: registered RAM output; s: skid entry holding the older beat when q is refilled.
  logic [DATA_WIDTH-1:0] r_q_data, r_s_data;
  logic                  r_q_vld, r_q_last, r_q_err;
  logic                  r_s_vld, r_s_last, r_s_err;
  logic                  w_arready, w_rvalid, w_pop, w_issue, w_q_moves;
  logic                  w_head_last, w_head_err, w_i_oor, w_i_last;
  logic [WordBits-1:0]   w_r_idx;

  assign w_rvalid    = r_s_vld | r_q_vld;
  assign w_pop       = w_rvalid & mem_rd.rready;
  assign w_head_last = r_s_vld ? r_s_last : r_q_last;
  assign w_head_err  = r_s_vld ? r_s_err : r_q_err;
  assign w_i_oor     = r_r_ptr[WordBits];
  assign w_i_last    = (r_r_icnt == {1'b0, r_r_len});
  assign w_r_idx     = r_r_ptr[WordBits-1:0];
  // Issue only if the two-entry pipeline will not overflow after this cycle's pop.
  assign w_issue     = (r_rstate == RData) && (r_r_icnt <= {1'b0, r_r_len}) && w_go_r &&
                       !(r_s_vld && !w_pop);
  assign w_q_moves   = w_issue && r_q_vld && !(w_pop && !r_s_vld);

  always_comb begin
    w_rstate_d = r_rstate;
    w_arready  = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        w_arready = r_live;
        if (mem_rd.arvalid && w_arready) w_rstate_d = RData;
      end
      RData: begin
        if (w_pop && w_head_last) w_rstate_d = RIdle;
      end
      default: w_rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate  <= RIdle;
      r_r_ptr   <= '0;
      r_r_fixed <= 1'b0;
      r_r_len   <= '0;
      r_r_icnt  <= '0;
      r_r_id    <= '0;
      r_r_err   <= 1'b0;
      r_q_vld   <= 1'b0;
      r_q_last  <= 1'b0;
      r_q_err   <= 1'b0;
      r_s_vld   <= 1'b0;
      r_s_last  <= 1'b0;
      r_s_err   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_d;
      if (mem_rd.arvalid && w_arready) begin
        r_r_ptr   <= to_ptr(mem_rd.araddr);
        r_r_fixed <= (mem_rd.arburst == 2'b00);
        r_r_len   <= mem_rd.arlen;
        r_r_icnt  <= '0;
        r_r_id    <= mem_rd.arid;
        r_r_err   <= mem_rd.arburst[1];
      end else if (w_issue) begin
        r_r_ptr  <= next_ptr(r_r_ptr, r_r_fixed);
        r_r_icnt <= r_r_icnt + 9'd1;
      end

      if (w_q_moves) begin
        r_s_vld  <= 1'b1;
        r_s_last <= r_q_last;
        r_s_err  <= r_q_err;
      end else if (w_pop && r_s_vld) begin
        r_s_vld <= 1'b0;
      end

      if (w_issue) begin
        r_q_vld  <= 1'b1;
        r_q_last <= w_i_last;
        r_q_err  <= w_i_oor | r_r_err;
      end else if (w_pop && !r_s_vld) begin
        r_q_vld <= 1'b0;
      end
    end
  end

  // Registered RAM read; a same-cycle write to the same word leaves the old value here.
  always_ff @(posedge clk_i) begin
    if (w_q_moves) r_s_data <= r_q_data;
    if (w_issue)   r_q_data <= w_i_oor ? '0 : r_mem[w_r_idx];
  end

  assign mem_rd.arready = w_arready;
  assign mem_rd.rvalid  = w_rvalid;
  assign mem_rd.rdata   = r_s_vld ? r_s_data : (r_q_vld ? r_q_data : '0);
  assign mem_rd.rresp   = (w_rvalid && w_head_err) ? 2'b10 : 2'b00;
  assign mem_rd.rlast   = w_rvalid & w_head_last;
  assign mem_rd.rid     = r_r_id;
  assign mem_rd.awready = 1'b0;
  assign mem_rd.wready  = 1'b0;
  assign mem_rd.bvalid  = 1'b0;
  assign mem_rd.bid     = '0;
  assign mem_rd.bresp   = 2'b00;

  logic w_unused_wr, w_unused_rd;
  assign w_unused_wr = ^{mem_wr.awsize, mem_wr.awlock, mem_wr.awcache, mem_wr.awprot,
                         mem_wr.awqos, mem_wr.arid, mem_wr.araddr, mem_wr.arlen, mem_wr.arsize,
                         mem_wr.arburst, mem_wr.arlock, mem_wr.arcache, mem_wr.arprot,
                         mem_wr.arqos, mem_wr.arvalid, mem_wr.rready};
  assign w_unused_rd = ^{mem_rd.awid, mem_rd.awaddr, mem_rd.awlen, mem_rd.awsize,
                         mem_rd.awburst, mem_rd.awlock, mem_rd.awcache, mem_rd.awprot,
                         mem_rd.awqos, mem_rd.awvalid, mem_rd.wdata, mem_rd.wstrb, mem_rd.wlast,
                         mem_rd.wvalid, mem_rd.bready, mem_rd.arsize, mem_rd.arlock,
                         mem_rd.arcache, mem_rd.arprot, mem_rd.arqos};

endmodule
